calc_result_writer: RTL and testbench
=====================================

# calc_result_writer

Result-side companion to the calc_ops operand readers. Op blocks (shift, add, …) emit one RAH_PACKET_WIDTH result word per operation as a single-cycle write pulse. This block buffers those results in a small circular FIFO and drains them into the RAH transmit FIFO. It honours that FIFO's `full` flag so no result is lost while space remains, and flags any result dropped when its own buffer is exhausted.

## Interface

- `RAH_PACKET_WIDTH`, 48, width of result and transmit words.
- `DEPTH`, 4, internal buffer entries; power of two, ≥ 2.

Ports:

- `clk`  in  1  single clock; all logic on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `res_data`  in  RAH_PACKET_WIDTH  result word from an op block.
- `res_valid`  in  1  one-cycle strobe; `res_data` is valid this cycle.
- `clr`  in  1  synchronous flush.
- `full`  in  1  transmit FIFO full; no write may be issued while high.
- `wr_data`  out  RAH_PACKET_WIDTH  word to transmit FIFO.
- `wren`  out  1  one-cycle write strobe per word.
- `level`  out  log2(DEPTH)+1  number of buffered words, 0..DEPTH.
- `overflow`  out  1  sticky: a result was dropped.

## Operation

- **Reset** (`rstn`=0, asynchronous): pointers=0, `level`=0, `wr_data`=0, `wren`=0, `overflow`=0. Buffer contents are don't-care.
- **Storage:** `mem[DEPTH]` with `wr_ptr` and `rd_ptr` of log2(DEPTH) bits. Pointers wrap naturally from DEPTH-1 to 0. `level` is a separate counter.
- **pop** (evaluated every cycle) = `level`≠0 && !`full` && !`clr`.
  - On pop: `wr_data` <= `mem[rd_ptr]`, `wren` <= 1, `rd_ptr`++.
  - Otherwise `wren` <= 0 and `wr_data` holds its value.
- **push** = `res_valid` && !`clr` && (`level`<DEPTH || pop).
  - On push: `mem[wr_ptr]` <= `res_data`, `wr_ptr`++.
- **Drop:** `res_valid` && !`clr` && `level`==DEPTH && !pop. The word is discarded and `overflow` <= 1.
- **Level update:** `level` += push − pop, so a simultaneous push and pop leaves it unchanged.
- **Full buffer:** with `level`==DEPTH and a pop in the same cycle, the incoming word is accepted.
- **Empty buffer:** with `level`==0, an incoming word is stored first. There is no bypass, so pop cannot take it the same cycle.
- **`clr`=1:** both pointers and `level` return to 0, `overflow` returns to 0, and `wren` <= 0.
  - `res_valid` in the same cycle is ignored and does not set `overflow`.
  - `wr_data` holds its value.
- **Order:** words leave in arrival order. No word is duplicated.
- **Back-pressure:** `full` is sampled in the same cycle as the pop decision. The transmit FIFO's `full` must already account for a write issued in the previous cycle, so `full` must not lag.
- **Reset mid-stream:** buffered words are discarded and `wren` drops asynchronously.

## Timing

- **Latency:** `res_valid` at cycle N into an empty buffer with `full`=0 produces `wren`=1 with that word in cycle N+2 (stored at edge N, popped at edge N+1).
- **Throughput:** one word per cycle in steady state. `wren` may stay high on consecutive cycles.
- **Stall:** `full` high in cycle M gives `wren`=0 in cycle M+1. `level` rises by 1 for each accepted `res_valid` until it reaches DEPTH.
- **Output timing:** `level` and `overflow` are registered and reflect the preceding edge. `wren` is never high during reset or in the cycle after a `clr` cycle.

## Test plan

- **Single word:** reset, then `res_valid` with `res_data`=0x0000_0000_00F0 at cycle 2, `full`=0 → `wren`=1 and `wr_data`=0x0000_0000_00F0 in cycle 4 only; `level` goes 0→1→0.
- **Burst under back-pressure:** hold `full`=1 and send 6 words 1..6 on consecutive cycles (DEPTH=4). Words 1–4 are stored, `level`=4, and `overflow`=1 after word 5. Release `full` → `wren` on 4 consecutive cycles with `wr_data` 1,2,3,4; words 5 and 6 never appear.
- **Simultaneous push and pop at full:** fill to `level`=4 with `full`=1. In one cycle drop `full` and strobe `res_valid` with 0xAA → `level` stays 4, `overflow` stays 0; the drained sequence ends with 0xAA.
- **Pointer wrap:** with `full`=0, stream 10 words 0x10..0x19 one per cycle → 10 `wren` pulses in exact order, `level` never exceeds 1, `overflow`=0.
- **Flush:** buffer 3 words with `overflow`=1, then `clr`=1 together with `res_valid` → next cycle `level`=0, `overflow`=0, `wren`=0; no buffered word is written after release.
- **Async reset:** assert `rstn`=0 mid-cycle while `wren`=1 and `level`=2 → `wren`, `level` and `wr_data` go to 0 immediately, before the next `clk` edge.

Source files
------------

// File: rtl/calc_result_writer.sv
// calc_result_writer
//   Buffers single-cycle result words from the op blocks in a small circular
//   FIFO and drains them, one per cycle, into the RAH transmit FIFO while that
//   FIFO is not full. Results arriving with the local buffer exhausted are
//   dropped and recorded in a sticky overflow flag.
//
// Ports
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   res_data  in   result word from an op block
//   res_valid in   one-cycle strobe qualifying res_data
//   clr       in   synchronous flush (pointers, level, overflow)
//   full      in   transmit FIFO full; no write issued while high
//   wr_data   out  word to transmit FIFO (holds between writes)
//   wren      out  one-cycle write strobe per word
//   level     out  number of buffered words, 0..DEPTH
//   overflow  out  sticky: a result was dropped
module calc_result_writer #(
  parameter int RAH_PACKET_WIDTH = 48,
  parameter int DEPTH            = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [RAH_PACKET_WIDTH-1:0]   res_data,
  input  logic                          res_valid,
  input  logic                          clr,
  input  logic                          full,
  output logic [RAH_PACKET_WIDTH-1:0]   wr_data,
  output logic                          wren,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [RAH_PACKET_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]               r_wr_ptr;
  logic [PW-1:0]               r_rd_ptr;
  logic [LW-1:0]               r_level;
  logic [RAH_PACKET_WIDTH-1:0] r_wr_data;
  logic                        r_wren;
  logic                        r_overflow;

  logic w_buf_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_buf_full = (r_level == LW'(DEPTH));
  assign w_pop      = (r_level != '0) && !full && !clr;
  // A full buffer still accepts a word when a slot frees up this cycle.
  assign w_push     = res_valid && !clr && (!w_buf_full || w_pop);
  assign w_drop     = res_valid && !clr && w_buf_full && !w_pop;

  // Storage needs no reset; contents are only read behind a non-zero level.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= res_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wr_data  <= '0;
      r_wren     <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_wren     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wren <= w_pop;
      if (w_pop) begin
        r_wr_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + PW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign wr_data  = r_wr_data;
  assign wren     = r_wren;
  assign level    = r_level;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_calc_result_writer.sv
module tb_calc_result_writer;

  localparam int W = 48;
  localparam int D = 4;

  logic         clk;
  logic         rstn;
  logic [W-1:0] res_data;
  logic         res_valid;
  logic         clr;
  logic         full;
  logic [W-1:0] wr_data;
  logic         wren;
  logic [2:0]   level;
  logic         overflow;

  int n_total = 0;
  int n_pass  = 0;
  int n_wren  = 0;
  logic [W-1:0] exp_q [$];

  calc_result_writer #(.RAH_PACKET_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .res_data(res_data), .res_valid(res_valid),
    .clr(clr), .full(full), .wr_data(wr_data), .wren(wren),
    .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
  endtask

  // Monitor: every write strobe must carry the oldest outstanding expected word.
  always @(negedge clk) begin
    if (rstn && wren) begin
      n_wren++;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_wren: got wr_data 0x%0h expected no write at %0t", wr_data, $time);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (wr_data === e) n_pass++;
        else $display("FAIL wr_data_order: got 0x%0h expected 0x%0h at %0t", wr_data, e, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] d, input bit expect_out);
    res_valid = 1'b1;
    res_data  = d;
    if (expect_out) exp_q.push_back(d);
  endtask

  task automatic drain(input string name, input int maxc);
    int i;
    for (i = 0; i < maxc; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int w0;
    logic [2:0] lmax;
    rstn = 1'b0; res_data = '0; res_valid = 1'b0; clr = 1'b0; full = 1'b0;
    #12;
    chk("rst_wren", 64'(wren), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    rstn = 1'b1;
    step();

    // Single word: store at edge N, write visible after edge N+1 only.
    send(48'h0000_0000_00F0, 1'b1);
    step();
    res_valid = 1'b0;
    chk("single_level1", 64'(level), 64'd1);
    chk("single_no_bypass", 64'(wren), 64'd0);
    step();
    chk("single_wren", 64'(wren), 64'd1);
    chk("single_data", 64'(wr_data), 64'h00F0);
    chk("single_level0", 64'(level), 64'd0);
    step();
    chk("single_wren_off", 64'(wren), 64'd0);

    // Burst of 6 under back-pressure: 1..4 kept, 5 and 6 dropped.
    full = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      send(48'(k), k <= 4);
      step();
      if (k == 4) begin
        chk("burst_level4", 64'(level), 64'd4);
        chk("burst_no_ovf_yet", 64'(overflow), 64'd0);
      end
      if (k == 5) chk("burst_ovf", 64'(overflow), 64'd1);
    end
    res_valid = 1'b0;
    chk("burst_stall_wren", 64'(wren), 64'd0);
    full = 1'b0;
    w0 = n_wren;
    drain("burst", 20);
    step();
    chk("burst_wren_count", 64'(n_wren - w0), 64'd4);
    chk("burst_level_end", 64'(level), 64'd0);
    chk("burst_ovf_sticky", 64'(overflow), 64'd1);

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 64'(overflow), 64'd0);

    // Push and pop together at full: 0xAA accepted, level stays 4.
    full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(48'hA1 + 48'(k), 1'b1);
      step();
    end
    chk("simul_level_pre", 64'(level), 64'd4);
    full = 1'b0;
    send(48'hAA, 1'b1);
    step();
    res_valid = 1'b0;
    chk("simul_level", 64'(level), 64'd4);
    chk("simul_ovf", 64'(overflow), 64'd0);
    drain("simul", 20);
    step();

    // Pointer wrap: 10 back-to-back words with no back-pressure.
    w0 = n_wren;
    lmax = '0;
    for (int k = 0; k < 10; k++) begin
      send(48'h10 + 48'(k), 1'b1);
      step();
      if (level > lmax) lmax = level;
    end
    res_valid = 1'b0;
    drain("wrap", 20);
    step();
    chk("wrap_level_max", 64'(lmax), 64'd1);
    chk("wrap_wren_count", 64'(n_wren - w0), 64'd10);
    chk("wrap_ovf", 64'(overflow), 64'd0);

    // Flush: 3 buffered words with overflow set, clr alongside res_valid.
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(48'hB1 + 48'(k), k == 0);
      step();
    end
    res_valid = 1'b0;
    full = 1'b0;
    step();
    full = 1'b1;
    chk("flush_level_pre", 64'(level), 64'd3);
    chk("flush_ovf_pre", 64'(overflow), 64'd1);
    full = 1'b0;
    clr = 1'b1;
    send(48'hCC, 1'b0);
    step();
    clr = 1'b0;
    res_valid = 1'b0;
    chk("flush_level", 64'(level), 64'd0);
    chk("flush_ovf", 64'(overflow), 64'd0);
    chk("flush_wren", 64'(wren), 64'd0);
    w0 = n_wren;
    repeat (6) step();
    chk("flush_no_writes", 64'(n_wren - w0), 64'd0);

    // Async reset while a write is on the output and two words remain.
    full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(48'hD1 + 48'(k), 1'b1);
      step();
    end
    res_valid = 1'b0;
    full = 1'b0;
    step();
    full = 1'b1;
    chk("arst_pre_wren", 64'(wren), 64'd1);
    chk("arst_pre_level", 64'(level), 64'd2);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst_wren", 64'(wren), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_wr_data", 64'(wr_data), 64'd0);
    exp_q.delete();
    #10;
    rstn = 1'b1;
    full = 1'b0;
    w0 = n_wren;
    repeat (4) step();
    chk("arst_no_writes", 64'(n_wren - w0), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

endmodule
